uart_autobaud_ctrl: RTL

//  Sets the 16-bit RX/TX baud divisor that drives the baud rate generator. Two sources:
//   - manual: a value written from the register set;
//   - auto-baud: measured from a 0x55 ('U') sync character on the RX line.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 44 ++++
 rtl/uart_autobaud_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART auto-baud controller and RX front end.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IDLE  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_WAIT_STOP  = 3'd4,
    ST_APPLY      = 3'd5
  } autobaud_state_t;

  localparam int SYNC_EDGES = 5;
  localparam int DIV_SHIFT  = 7;
  localparam int DIV_ROUND  = 64;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchroniser; with AUTOBAUD_GLITCH_FILTER_EN defined a 3-sample
// majority filter follows the two flops and rejects single-cycle pulses.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async,
  output logic rx_clean
);
  import uart_pkg::*;

  logic rx_p0;
  logic rx_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_async;
      rx_p1 <= rx_p0;
    end
  end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
  logic rx_p2;
  logic rx_p3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p2 <= 1'b1;
      rx_p3 <= 1'b1;
    end else begin
      rx_p2 <= rx_p1;
      rx_p3 <= rx_p2;
    end
  end

  // Majority of the synchronised sample and its two predecessors: one cycle of delay
  assign rx_clean = (rx_p1 & rx_p2) | (rx_p1 & rx_p3) | (rx_p2 & rx_p3);
`else
  assign rx_clean = rx_p1;
`endif

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Baud divisor controller: manual load or auto-baud measurement on a 0x55 sync
// character. Optional RX glitch filter enabled by AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud_ctrl #(
  parameter logic [15:0] DEF_DIV  = 16'd27,
  parameter logic [15:0] MIN_DIV  = 16'd1,
  parameter int          CNT_W    = 24,
  parameter int          IDLE_CYC = 64
) (
  input  logic        uart_clk_i,
  input  logic        uart_rst_n_i,
  input  logic        rx_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        sw_div_wr_i,
  input  logic [15:0] sw_div_i,
  output logic [15:0] baud_div_o,
  output logic        gen_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  import uart_pkg::*;

  localparam int IDLE_W = $clog2(IDLE_CYC + 1);

  autobaud_state_t state;
  autobaud_state_t next_state;

  logic              rx_clean;
  logic              rx_prev;
  logic              fall;
  logic              rise;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        edge_cnt;
  logic [CNT_W-1:0]  span;
  logic [CNT_W-1:0]  low_cnt;
  logic [CNT_W-1:0]  stop_lim;
  logic              cnt_max;
  logic              last_edge;
  logic              abort_hit;
  logic [CNT_W:0]    div_wide;
  logic              div_ok;

  logic              done_nxt;
  logic              err_nxt;
  logic              div_load;
  logic [15:0]       div_val;

  // Span covers 8 bit times, so rounded span/128 is the x16 divisor
  function automatic logic [CNT_W:0] calc_div(input logic [CNT_W-1:0] s);
    logic [CNT_W:0] sum;
    sum = {1'b0, s} + (CNT_W + 1)'(DIV_ROUND);
    return sum >> DIV_SHIFT;
  endfunction

  uart_rx_sync u_rx_sync (
    .clk      (uart_clk_i),
    .rst_n    (uart_rst_n_i),
    .rx_async (rx_i),
    .rx_clean (rx_clean)
  );

  assign fall      = rx_prev & ~rx_clean;
  assign rise      = ~rx_prev & rx_clean;
  assign cnt_max   = &cnt;
  assign last_edge = fall && (edge_cnt == 3'(SYNC_EDGES - 1));
  assign stop_lim  = span >> 2;
  assign abort_hit = abort_i && (state != ST_IDLE);
  assign div_wide  = calc_div(span);
  assign div_ok    = (div_wide <= (CNT_W + 1)'(16'hFFFF)) &&
                     (div_wide >= (CNT_W + 1)'(MIN_DIV));

  always_ff @(posedge uart_clk_i) begin
    if (!uart_rst_n_i) state <= ST_IDLE;
    else               state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (start_i) next_state = ST_WAIT_IDLE;
        ST_WAIT_IDLE:  if (rx_clean && idle_cnt == IDLE_W'(IDLE_CYC - 1))
                         next_state = ST_WAIT_START;
        ST_WAIT_START: if (fall) next_state = ST_MEASURE;
        ST_MEASURE: begin
          if (last_edge)    next_state = ST_WAIT_STOP;
          else if (cnt_max) next_state = ST_IDLE;
        end
        ST_WAIT_STOP: begin
          if (rise)                     next_state = ST_APPLY;
          else if (low_cnt >= stop_lim) next_state = ST_IDLE;
        end
        ST_APPLY:      next_state = ST_IDLE;
        default:       next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    div_load = 1'b0;
    div_val  = baud_div_o;
    if (!abort_hit) begin
      case (state)
        ST_IDLE: begin
          if (sw_div_wr_i && !start_i) begin
            div_load = 1'b1;
            div_val  = sw_div_i;
          end
        end
        ST_MEASURE:   if (!last_edge && cnt_max) err_nxt = 1'b1;
        ST_WAIT_STOP: if (!rise && low_cnt >= stop_lim) err_nxt = 1'b1;
        ST_APPLY: begin
          if (div_ok) begin
            div_load = 1'b1;
            div_val  = div_wide[15:0];
            done_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge uart_clk_i) begin
    if (!uart_rst_n_i) begin
      baud_div_o  <= DEF_DIV;
      gen_rst_n_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (div_load) baud_div_o <= div_val;
      gen_rst_n_o <= ~div_load;
      busy_o      <= (next_state != ST_IDLE);
      done_o      <= done_nxt;
      err_o       <= err_nxt;
    end
  end

  // Measurement counters; the line idles high so the edge history resets to 1
  always_ff @(posedge uart_clk_i) begin
    if (!uart_rst_n_i) begin
      rx_prev  <= 1'b1;
      idle_cnt <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      span     <= '0;
      low_cnt  <= '0;
    end else begin
      rx_prev <= rx_clean;
      case (state)
        ST_WAIT_IDLE: idle_cnt <= rx_clean ? idle_cnt + IDLE_W'(1) : '0;
        ST_WAIT_START: begin
          if (fall) begin
            cnt      <= '0;
            edge_cnt <= 3'd1;
          end
        end
        ST_MEASURE: begin
          cnt     <= cnt + CNT_W'(1);
          low_cnt <= '0;
          if (fall) begin
            edge_cnt <= edge_cnt + 3'd1;
            if (last_edge) span <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_STOP: low_cnt <= low_cnt + CNT_W'(1);
        default: begin
          idle_cnt <= '0;
          low_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
